alu_mdu_unit: RTL
=================

// Module: alu_mdu_unit
// PURPOSE
//  Parametrised execute-stage unit: combinational ALU + barrel shifter, plus an
//  iterative multiply engine with HI/LO registers and start/busy/done handshake.
//  Sits in EX of the pipelined CPU; drives result/zero to EX/MEM, raises stall
//  to hazard unit while HI/LO read would see stale data.
// PARAMETERS
//  WIDTH      32  datapath width (even, >=8)
//  SHAMT_W    5   shift-amount width; must equal clog2(WIDTH)
//  STEP_BITS  1   multiplier bits retired per cycle; must divide WIDTH
// PORTS
//  clk       in   1         clock, rising edge
//  rst       in   1         asynchronous reset, active-high
//  alu_op    in   3         000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT(signed)
//  out_sel   in   2         00 ALU, 01 HI, 10 LO, 11 shifter
//  sht_dir   in   1         0 SLL, 1 SRL (logical) on dataB by shamt
//  dataA     in   WIDTH     rs operand
//  dataB     in   WIDTH     rt operand
//  shamt     in   SHAMT_W   shift amount
//  md_start  in   1         request multiply/divide op (1-cycle qualifier)
//  md_op     in   2         00 MULTU, 01 MULT(signed), 10 DIVU (opt), 11 rsvd
//  hi_we     in   1         MTHI: HI <= dataA
//  lo_we     in   1         MTLO: LO <= dataA
//  result    out  WIDTH     selected output (combinational)
//  zero      out  1         1 when ALU result == 0 (independent of out_sel)
//  md_busy   out  1         engine in RUN or FIN
//  md_done   out  1         1-cycle pulse, HI/LO written this edge
//  stall     out  1         md_busy && out_sel in {HI,LO}
// BEHAVIOUR
//  - Reset: HI=LO=0, FSM=IDLE, md_busy=md_done=0, counter=0; result/zero follow
//    inputs combinationally (HI/LO paths read 0).
//  - ALU: ADD/SUB wrap mod 2^WIDTH, no overflow trap; SLT gives 1/0 zero-extended.
//    Undefined alu_op codes -> result 0.
//  - FSM IDLE -> RUN on md_start with legal md_op; operands latched that edge.
//    RUN lasts WIDTH/STEP_BITS cycles; then FIN (1 cycle): HI/LO <= {hi,lo} of
//    product, md_done=1. FIN -> RUN if md_start accepted in FIN, else IDLE.
//  - Latency: start at edge N -> HI/LO valid after edge N+WIDTH/STEP_BITS+1.
//  - md_start ignored while in RUN (no queueing); accepted in IDLE and FIN.
//  - MULT signed: magnitudes multiplied, product negated at FIN if signs differ;
//    -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2) exact.
//  - hi_we/lo_we ignored while md_busy; honoured in IDLE; both may fire together.
//  - HI/LO reads during busy return old values; stall flags it.
//  - rst mid-operation aborts: FSM IDLE, HI/LO cleared, no md_done.
// CONFIGURATION
//  ALU_MDU_DIVU_EN defined: md_op=10 runs restoring DIVU, same latency;
//    LO=quotient, HI=remainder; divisor 0 -> LO=all-ones, HI=dataA.
//  Undefined: md_op 10/11 are illegal; md_start with them ignored, stays IDLE.
// STRUCTURE
//  - Package exec_pkg: alu_op, out_sel, md_op codes; mdu_state_t {IDLE,RUN,FIN}.
//  - Sub-module mdu_seq: iterative mul/div engine, counter, FSM, HI/LO regs.
//  - Top: ALU, shifter, output mux combinational; instantiates mdu_seq.
// TESTING
//  - ADD 0x7FFFFFFF+1 -> 0x80000000, zero=0; SUB 5-5 -> 0, zero=1;
//    SLT 0xFFFFFFFF,1 -> 1.
//  - SLL dataB=1 shamt=31 -> 0x80000000; SRL 0x80000000 by 31 -> 1.
//  - MULTU 0xFFFFFFFF*0xFFFFFFFF: done at start+33 edges, HI=0xFFFFFFFE, LO=1;
//    out_sel=HI during RUN -> stall=1, old HI.
//  - MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; start in FIN cycle chains.
//  - rst at RUN cycle 10 -> busy=0, HI=LO=0, no done pulse; MTHI while busy no-op.
//  - DIVU_EN: 100/7 -> LO=14, HI=2; 9/0 -> LO=0xFFFFFFFF, HI=9; without macro
//    md_op=10 start -> md_busy stays 0.

Source files
------------

// File: rtl/alu_mdu_unit_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared encodings for the execute-stage ALU/MDU slice: ALU operation codes,
// output-select codes, multiply/divide operation codes and the MDU FSM states.
// mdOpLegal() tells the engine which md_op codes it may accept; the divide
// code becomes legal only when ALU_MDU_DIVU_EN is defined.
// ---------------------------------------------------------------------------
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } aluOp_t;

    typedef enum logic [1:0] {
        SEL_ALU   = 2'b00,
        SEL_HI    = 2'b01,
        SEL_LO    = 2'b10,
        SEL_SHIFT = 2'b11
    } outSel_t;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_RSVD  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } mduState_t;

    function automatic logic mdOpLegal(input logic [1:0] op);
`ifdef ALU_MDU_DIVU_EN
        return (op == MD_MULTU) || (op == MD_MULT) || (op == MD_DIVU);
`else
        return (op == MD_MULTU) || (op == MD_MULT);
`endif
    endfunction

endpackage

// File: rtl/alu_mdu_unit_if.sv
// ---------------------------------------------------------------------------
// alu_mdu_unit_if
// Bundles the EX-stage operand, control and result signals of alu_mdu_unit.
//   master : pipeline side, drives operands/controls, observes results
//   slave  : the execute unit itself
// Signals: alu_op, out_sel, sht_dir, dataA, dataB, shamt, md_start, md_op,
//          hi_we, lo_we (to unit); result, zero, md_busy, md_done, stall
//          (from unit).
// ---------------------------------------------------------------------------
interface alu_mdu_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic [2:0]         alu_op;
    logic [1:0]         out_sel;
    logic               sht_dir;
    logic [WIDTH-1:0]   dataA;
    logic [WIDTH-1:0]   dataB;
    logic [SHAMT_W-1:0] shamt;
    logic               md_start;
    logic [1:0]         md_op;
    logic               hi_we;
    logic               lo_we;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               md_busy;
    logic               md_done;
    logic               stall;

    modport master (
        output alu_op, out_sel, sht_dir, dataA, dataB, shamt,
               md_start, md_op, hi_we, lo_we,
        input  result, zero, md_busy, md_done, stall
    );

    modport slave (
        input  alu_op, out_sel, sht_dir, dataA, dataB, shamt,
               md_start, md_op, hi_we, lo_we,
        output result, zero, md_busy, md_done, stall
    );
endinterface

// File: rtl/alu_mdu_unit_mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq
// Iterative multiply (and optional restoring unsigned divide) engine with the
// HI/LO register pair. IDLE -> RUN (WIDTH/STEP_BITS cycles) -> FIN, HI/LO
// written and done pulsed on the edge that leaves FIN. A new start may be
// accepted in IDLE or FIN; starts during RUN are dropped.
// Optional feature macro: ALU_MDU_DIVU_EN (enables md_op=DIVU).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, mdOp     operation request and code
//   opA, opB        rs/rt operands (also MTHI/MTLO data on opA)
//   hiWe, loWe      MTHI/MTLO write enables, honoured only in IDLE
//   hi, lo          HI/LO register contents
//   busy, done      engine in RUN/FIN; one-cycle completion pulse
// ---------------------------------------------------------------------------
module mdu_seq import exec_pkg::*; #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mdOp,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             hiWe,
    input  logic             loWe,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int NSTEPS = WIDTH / STEP_BITS;
    localparam int CNT_W  = $clog2(NSTEPS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEPS - 1);

    mduState_t          state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               negRes;
    logic [2*WIDTH-1:0] prodNext;
    logic [2*WIDTH-1:0] prodFinal;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic               signedOp;
    logic               accept;
`ifdef ALU_MDU_DIVU_EN
    logic               isDiv;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH:0]     remNext;
    logic [WIDTH-1:0]   quoNext;
`endif

    // Signed multiply works on magnitudes; the most negative value maps to
    // 2^(WIDTH-1) as an unsigned magnitude, so its square stays exact.
    assign signedOp  = (mdOp == MD_MULT);
    assign magA      = (signedOp && opA[WIDTH-1]) ? -opA : opA;
    assign magB      = (signedOp && opB[WIDTH-1]) ? -opB : opB;
    assign accept    = start && mdOpLegal(mdOp) && (state != RUN);
    assign busy      = (state != IDLE);
    assign prodFinal = negRes ? -prod : prod;

    // One RUN cycle of shift-and-add: retire STEP_BITS multiplier bits.
    always_comb begin
        prodNext = prod;
        for (int k = 0; k < STEP_BITS; k++) begin
            if (mplier[k]) prodNext = prodNext + (mcand << k);
        end
    end

`ifdef ALU_MDU_DIVU_EN
    // One RUN cycle of restoring division: STEP_BITS quotient bits. A zero
    // divisor always "fits", giving an all-ones quotient and remainder=dividend.
    always_comb begin
        remNext = rem;
        quoNext = quo;
        for (int k = 0; k < STEP_BITS; k++) begin
            remNext = {remNext[WIDTH-1:0], quoNext[WIDTH-1]};
            quoNext = quoNext << 1;
            if (remNext >= {1'b0, divisor}) begin
                remNext    = remNext - {1'b0, divisor};
                quoNext[0] = 1'b1;
            end
        end
    end
`endif

    // Engine FSM, operand latching and HI/LO update. A start accepted in FIN
    // overrides the return to IDLE, so back-to-back ops chain without a gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            negRes  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
`ifdef ALU_MDU_DIVU_EN
            isDiv   <= 1'b0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hiWe) hi <= opA;
                    if (loWe) lo <= opA;
                end
                RUN: begin
                    prod   <= prodNext;
                    mcand  <= mcand << STEP_BITS;
                    mplier <= mplier >> STEP_BITS;
`ifdef ALU_MDU_DIVU_EN
                    rem    <= remNext;
                    quo    <= quoNext;
`endif
                    count  <= count + CNT_W'(1);
                    if (count == LAST) state <= FIN;
                end
                FIN: begin
`ifdef ALU_MDU_DIVU_EN
                    if (isDiv) begin
                        hi <= rem[WIDTH-1:0];
                        lo <= quo;
                    end else begin
                        {hi, lo} <= prodFinal;
                    end
`else
                    {hi, lo} <= prodFinal;
`endif
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                state   <= RUN;
                count   <= '0;
                prod    <= '0;
                mcand   <= {{WIDTH{1'b0}}, magA};
                mplier  <= magB;
                negRes  <= signedOp && (opA[WIDTH-1] ^ opB[WIDTH-1]);
`ifdef ALU_MDU_DIVU_EN
                isDiv   <= (mdOp == MD_DIVU);
                rem     <= '0;
                quo     <= opA;
                divisor <= opB;
`endif
            end
        end
    end
endmodule

// File: rtl/alu_mdu_unit.sv
// ---------------------------------------------------------------------------
// alu_mdu_unit
// Execute-stage unit: combinational ALU and logical barrel shifter, an output
// mux selecting ALU / HI / LO / shifter, and the iterative MDU (mdu_seq).
// stall warns the hazard unit that a HI/LO read would see stale data.
// Optional feature macro: ALU_MDU_DIVU_EN (unsigned divide in the MDU).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        alu_mdu_unit_if.slave (operands, controls, result, zero,
//              md_busy, md_done, stall)
// ---------------------------------------------------------------------------
module alu_mdu_unit import exec_pkg::*; #(
    parameter int WIDTH     = 32,
    parameter int SHAMT_W   = 5,
    parameter int STEP_BITS = 1
) (
    input  logic           clk,
    input  logic           rst,
    alu_mdu_unit_if.slave  bus
);
    logic [WIDTH-1:0]   aluRes;
    logic [WIDTH-1:0]   shiftRes;
    logic [WIDTH-1:0]   hiVal;
    logic [WIDTH-1:0]   loVal;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = bus.shamt;

    // ALU: arithmetic wraps silently; unlisted op codes produce zero.
    always_comb begin
        aluRes = '0;
        case (bus.alu_op)
            ALU_AND: aluRes = bus.dataA & bus.dataB;
            ALU_OR:  aluRes = bus.dataA | bus.dataB;
            ALU_ADD: aluRes = bus.dataA + bus.dataB;
            ALU_SUB: aluRes = bus.dataA - bus.dataB;
            ALU_SLT: aluRes = {{(WIDTH-1){1'b0}}, ($signed(bus.dataA) < $signed(bus.dataB))};
            default: aluRes = '0;
        endcase
    end

    assign shiftRes = bus.sht_dir ? (bus.dataB >> shamt) : (bus.dataB << shamt);

    // Output mux; zero always reflects the ALU, whatever is being selected.
    always_comb begin
        bus.result = aluRes;
        case (bus.out_sel)
            SEL_ALU:   bus.result = aluRes;
            SEL_HI:    bus.result = hiVal;
            SEL_LO:    bus.result = loVal;
            SEL_SHIFT: bus.result = shiftRes;
            default:   bus.result = aluRes;
        endcase
    end

    assign bus.zero  = (aluRes == '0);
    assign bus.stall = bus.md_busy && ((bus.out_sel == SEL_HI) || (bus.out_sel == SEL_LO));

    mdu_seq #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS)
    ) mduSeq (
        .clk   (clk),
        .rst   (rst),
        .start (bus.md_start),
        .mdOp  (bus.md_op),
        .opA   (bus.dataA),
        .opB   (bus.dataB),
        .hiWe  (bus.hi_we),
        .loWe  (bus.lo_we),
        .hi    (hiVal),
        .lo    (loVal),
        .busy  (bus.md_busy),
        .done  (bus.md_done)
    );
endmodule
